// File: rtl/alu_result_queue.sv
// ALU result queue: small FIFO between the ALU and writeback,
// tagging each result with its op code and zero/neg/slt flags.
module alu_result_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_slt,
  output logic [CNT_W-1:0] count,
  output logic             ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [2:0] OP_SLT = 3'b101;

  logic [WIDTH-1:0] res_mem_q [DEPTH];
  logic [2:0]       op_mem_q  [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             push, pop;

  always_comb begin
    in_ready  = (cnt_q != FULL);
    out_valid = (cnt_q != '0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // a dropped push while full latches until reset
    if (in_valid && !in_ready) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_mem_q[wr_ptr_q] <= in_result;
      op_mem_q[wr_ptr_q]  <= in_op;
    end
  end

  // head reads as zero when empty so stale storage never leaks out
  always_comb begin
    out_result = out_valid ? res_mem_q[rd_ptr_q] : '0;
    out_op     = out_valid ? op_mem_q[rd_ptr_q]  : '0;
    out_zero   = ~|out_result;
    out_neg    = out_result[WIDTH-1];
    out_slt    = (out_op == OP_SLT) && (out_result == WIDTH'(1));
  end

  assign count   = cnt_q;
  assign ovf_err = ovf_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Bench for alu_result_queue: directed table, corner sequences
// and a random run against a queue-based reference model.
module tb_alu_result_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_op;
  logic             out_zero;
  logic             out_neg;
  logic             out_slt;
  logic [CNT_W-1:0] count;
  logic             ovf_err;

  int checks   = 0;
  int failures = 0;

  alu_result_queue #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_op    (out_op),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_slt   (out_slt),
    .count     (count),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  cnt;
    logic        ov;
    logic        ir;
    logic [31:0] res;
    logic [2:0]  op;
    logic        z;
    logic        n;
    logic        s;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [2:0]  op;
    logic        ordy;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  op;
  } ent_t;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, exp_t e);
    chk({tag, ".count"},     32'(count),      32'(e.cnt));
    chk({tag, ".out_valid"}, 32'(out_valid),  32'(e.ov));
    chk({tag, ".in_ready"},  32'(in_ready),   32'(e.ir));
    chk({tag, ".out_res"},   out_result,      e.res);
    chk({tag, ".out_op"},    32'(out_op),     32'(e.op));
    chk({tag, ".zero"},      32'(out_zero),   32'(e.z));
    chk({tag, ".neg"},       32'(out_neg),    32'(e.n));
    chk({tag, ".slt"},       32'(out_slt),    32'(e.s));
    chk({tag, ".ovf_err"},   32'(ovf_err),    32'(e.ovf));
  endtask

  task automatic drive(logic r, logic iv, logic [31:0] d,
                       logic [2:0] op, logic ordy);
    reset     = r;
    in_valid  = iv;
    in_result = d;
    in_op     = op;
    out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[11];
    ent_t mq[$];
    logic movf;
    exp_t e;

    // {iv, data, op, ordy, {cnt, ov, ir, res, op, z, n, s, ovf}}
    vt[0]  = '{1'b1, 32'h5, 3'd0, 1'b0,
               '{3'd1, 1, 1, 32'h5, 3'd0, 0, 0, 0, 0}};
    vt[1]  = '{1'b0, 32'h0, 3'd0, 1'b1,
               '{3'd0, 0, 1, 32'h0, 3'd0, 1, 0, 0, 0}};
    vt[2]  = '{1'b1, 32'h0, 3'd0, 1'b0,
               '{3'd1, 1, 1, 32'h0, 3'd0, 1, 0, 0, 0}};
    vt[3]  = '{1'b1, 32'h8000_0000, 3'd0, 1'b0,
               '{3'd2, 1, 1, 32'h0, 3'd0, 1, 0, 0, 0}};
    vt[4]  = '{1'b1, 32'h1, 3'd5, 1'b0,
               '{3'd3, 1, 1, 32'h0, 3'd0, 1, 0, 0, 0}};
    vt[5]  = '{1'b1, 32'hFFFF_FFFF, 3'd7, 1'b0,
               '{3'd4, 1, 0, 32'h0, 3'd0, 1, 0, 0, 0}};
    vt[6]  = '{1'b1, 32'h1234, 3'd0, 1'b0,
               '{3'd4, 1, 0, 32'h0, 3'd0, 1, 0, 0, 1}};
    vt[7]  = '{1'b0, 32'h0, 3'd0, 1'b1,
               '{3'd3, 1, 1, 32'h8000_0000, 3'd0, 0, 1, 0, 1}};
    vt[8]  = '{1'b0, 32'h0, 3'd0, 1'b1,
               '{3'd2, 1, 1, 32'h1, 3'd5, 0, 0, 1, 1}};
    vt[9]  = '{1'b0, 32'h0, 3'd0, 1'b1,
               '{3'd1, 1, 1, 32'hFFFF_FFFF, 3'd7, 0, 1, 0, 1}};
    vt[10] = '{1'b0, 32'h0, 3'd0, 1'b1,
               '{3'd0, 0, 1, 32'h0, 3'd0, 1, 0, 0, 1}};

    drive(1'b1, 1'b0, 32'h0, 3'd0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 32'h0, 3'd0, 1'b0);
    tick();
    chk_all("reset_idle", '{3'd0, 0, 1, 32'h0, 3'd0, 1, 0, 0, 0});

    for (int i = 0; i < 11; i++) begin
      drive(1'b0, vt[i].iv, vt[i].d, vt[i].op, vt[i].ordy);
      tick();
      chk_all($sformatf("vec%0d", i), vt[i].e);
    end

    // streaming: one in, one out per cycle, pointers wrap
    drive(1'b0, 1'b1, 32'd1, 3'd0, 1'b1);
    tick();
    chk("stream.first", out_result, 32'd1);
    for (int v = 2; v <= 10; v++) begin
      drive(1'b0, 1'b1, 32'(v), 3'd0, 1'b1);
      tick();
      chk($sformatf("stream.cnt%0d", v), 32'(count), 32'd1);
      chk($sformatf("stream.res%0d", v), out_result, 32'(v));
    end
    drive(1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
    tick();
    chk("stream.drained", 32'(count), 32'd0);

    // reset with traffic: fill 3, then reset alongside push and pop
    for (int v = 0; v < 3; v++) begin
      drive(1'b0, 1'b1, 32'h100 + 32'(v), 3'd1, 1'b0);
      tick();
    end
    chk("rst.pre_count", 32'(count), 32'd3);
    drive(1'b1, 1'b1, 32'h999, 3'd2, 1'b1);
    tick();
    chk_all("rst.traffic", '{3'd0, 0, 1, 32'h0, 3'd0, 1, 0, 0, 0});
    drive(1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
    tick();
    chk_all("rst.after", '{3'd0, 0, 1, 32'h0, 3'd0, 1, 0, 0, 0});

    // full with simultaneous pop and push: push refused this cycle
    for (int v = 0; v < 4; v++) begin
      drive(1'b0, 1'b1, 32'h10 + 32'(v), 3'd0, 1'b0);
      tick();
    end
    chk("full.count", 32'(count), 32'd4);
    chk("full.ovf", 32'(ovf_err), 32'd0);
    drive(1'b0, 1'b1, 32'hAA, 3'd3, 1'b1);
    tick();
    chk("full.pop_count", 32'(count), 32'd3);
    chk("full.pop_head", out_result, 32'h11);
    chk("full.pop_ovf", 32'(ovf_err), 32'd1);
    drive(1'b0, 1'b1, 32'hAA, 3'd3, 1'b0);
    tick();
    chk("full.repush_count", 32'(count), 32'd4);
    chk("full.repush_ready", 32'(in_ready), 32'd0);
    for (int v = 0; v < 4; v++) begin
      logic [31:0] want [4];
      want = '{32'h11, 32'h12, 32'h13, 32'hAA};
      chk($sformatf("full.drain%0d", v), out_result, want[v]);
      drive(1'b0, 1'b0, 32'h0, 3'd0, 1'b1);
      tick();
    end
    chk("full.empty", 32'(out_valid), 32'd0);

    // random traffic vs queue model
    drive(1'b1, 1'b0, 32'h0, 3'd0, 1'b0);
    tick();
    mq.delete();
    movf = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic r, iv, ordy, full;
      logic [31:0] d;
      logic [2:0] op;
      r    = ($urandom_range(0, 59) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = $urandom_range(0, 1);
      op   = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0:       d = 32'h0;
        1:       d = 32'h1;
        2:       d = 32'h8000_0000 | $urandom;
        default: d = $urandom;
      endcase
      drive(r, iv, d, op, ordy);

      full = (mq.size() == DEPTH);
      if (r) begin
        mq.delete();
        movf = 1'b0;
      end else begin
        if (iv && full) movf = 1'b1;
        if (ordy && mq.size() != 0) void'(mq.pop_front());
        if (iv && !full) mq.push_back('{d, op});
      end
      tick();

      e.cnt = 3'(mq.size());
      e.ov  = (mq.size() != 0);
      e.ir  = (mq.size() != DEPTH);
      e.res = e.ov ? mq[0].r  : 32'h0;
      e.op  = e.ov ? mq[0].op : 3'd0;
      e.z   = (e.res == 32'h0);
      e.n   = e.res[31];
      e.s   = (e.op == 3'b101) && (e.res == 32'h1);
      e.ovf = movf;
      chk_all($sformatf("rnd%0d", i), e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
